// File: rtl/mem_line_server_pkg.sv
// Shared widths and FSM encoding for the line server and its storage array.
package mem_line_server_pkg;
   localparam int LINE_W     = 128;
   localparam int MEM_ADDR_W = 28;
   localparam int CNT_W      = 4;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] RESP = 2'd2;
endpackage

// File: rtl/mem_line_array.sv
// LINES x LINE_W line storage: one synchronous write port and one
// combinational read port; contents are deliberately not reset.
module mem_line_array
   import mem_line_server_pkg::*;
#(
   parameter int LINES = 256,
   parameter int AW    = $clog2(LINES)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [LINE_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [LINE_W-1:0] rdata
);
   logic [LINE_W-1:0] mem [LINES];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/mem_line_server.sv
// Fixed-latency 128-bit line server: accepts one read/write from IDLE, counts
// LATENCY edges, then pulses mem_ready for one cycle in RESP.
module mem_line_server
   import mem_line_server_pkg::*;
#(
   parameter int LATENCY = 4,
   parameter int LINES   = 256
) (
   input  logic                  clk,
   input  logic                  proc_reset,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [MEM_ADDR_W-1:0] mem_addr,
   input  logic [LINE_W-1:0]     mem_wdata,
   output logic [LINE_W-1:0]     mem_rdata,
   output logic                  mem_ready,
   output logic                  proto_err
);
   localparam int AW = $clog2(LINES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   generate
      if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
         $error("mem_line_server: LATENCY must be within 1..15");
      end
      if ((1 << AW) != LINES) begin : g_bad_lines
         $error("mem_line_server: LINES must be a power of two");
      end
   endgenerate

   logic [1:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic              op_write;
   logic [AW-1:0]     addr_q;
   logic [LINE_W-1:0] wdata_q;

   logic              idle, req, cur_write, enter_resp;
   logic [AW-1:0]     cur_idx;
   logic [LINE_W-1:0] cur_wdata, rd_line;
   logic              unused_addr_hi;

   // Upper address bits alias onto the same lines.
   assign unused_addr_hi = ^mem_addr[MEM_ADDR_W-1:AW];

   // With LATENCY=1 the accepting edge is also the completing edge, so the
   // live inputs stand in for the not-yet-latched request fields.
   assign idle       = (state == IDLE);
   assign req        = mem_read | mem_write;
   assign cur_write  = idle ? mem_write : op_write;
   assign cur_idx    = idle ? mem_addr[AW-1:0] : addr_q;
   assign cur_wdata  = idle ? mem_wdata : wdata_q;
   assign enter_resp = (idle && req && LATENCY == 1) ||
                       (state == BUSY && cnt == 4'd1);

   mem_line_array #(.LINES(LINES), .AW(AW)) u_array (
      .clk   (clk),
      .we    (enter_resp & cur_write),
      .waddr (cur_idx),
      .wdata (cur_wdata),
      .raddr (cur_idx),
      .rdata (rd_line)
   );

   always_ff @(posedge clk or posedge proc_reset) begin
      if (proc_reset) begin
         state     <= IDLE;
         cnt       <= '0;
         op_write  <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         mem_rdata <= '0;
         mem_ready <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         mem_ready <= enter_resp;
         if (enter_resp && !cur_write) mem_rdata <= rd_line;
         case (state)
            IDLE: begin
               if (req) begin
                  op_write <= mem_write;
                  addr_q   <= mem_addr[AW-1:0];
                  wdata_q  <= mem_wdata;
                  cnt      <= CNT_LOAD;
                  if (mem_read && mem_write) proto_err <= 1'b1;
                  state    <= (LATENCY == 1) ? RESP : BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= RESP;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
